// File: rtl/rom_streamer_pkg.sv
// rtl/rom_streamer_pkg.sv - shared state encoding and buffer depth for rom_streamer
package rom_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/rom_stream_fifo.sv
// rtl/rom_stream_fifo.sv - two-entry output buffer holding ROM word plus last tag
module rom_stream_fifo
    import rom_streamer_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full buffer is only accepted when the head leaves in the same edge.
    assign pop_ok  = pop && (occ != '0);
    assign push_ok = push && ((occ != OCC_W'(FIFO_DEPTH)) || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching stored words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {{(OCC_W-1){1'b0}}, push_ok} - {{(OCC_W-1){1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - walks a one-cycle-latency ROM and streams words with backpressure
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int LAST_ADDR  = 255,
    parameter int LOOP       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    pend;
    logic                    pend_last;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W:0]          inflight;
    logic                    pop;
    logic                    issue;
    logic                    flush;
    logic [DATA_WIDTH:0]     head;

    // Words buffered plus the read in flight, minus the one leaving now, must leave room.
    assign pop      = m_valid && m_ready;
    assign inflight = {1'b0, occ} + {{OCC_W{1'b0}}, pend} - {{OCC_W{1'b0}}, pop};
    assign issue    = (state == ST_RUN) && (inflight < (OCC_W+1)'(FIFO_DEPTH));
    assign flush    = stop && (state != ST_IDLE);

    assign rom_addr = addr;
    assign busy     = (state != ST_IDLE);
    assign m_valid  = (occ != '0);
    assign m_data   = head[DATA_WIDTH-1:0];
    assign m_last   = head[DATA_WIDTH] && m_valid;

    rom_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (pend),
        .pop   (pop),
        .din   ({pend_last, rom_dout}),
        .dout  (head),
        .occ   (occ)
    );

    // Sequencer: address walk, read-pending pipeline with last tag, and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state     <= ST_IDLE;
                addr      <= '0;
                pend      <= 1'b0;
                pend_last <= 1'b0;
            end else begin
                pend      <= issue;
                pend_last <= issue && (addr == LAST);
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_RUN;
                            addr  <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (issue) begin
                            addr <= (addr == LAST) ? '0 : addr + ADDR_WIDTH'(1);
                            if ((addr == LAST) && (LOOP == 0)) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!pend && (occ == '0)) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - self-checking bench for rom_streamer
module tb_rom_streamer;

    localparam int DW = 10;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0 = 1'b0, stop0 = 1'b0, ready0 = 1'b0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] rom0 = '0, data0;
    logic          valid0, last0, busy0, done0;

    logic          start1 = 1'b0, stop1 = 1'b0, ready1 = 1'b0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] rom1 = '0, data1;
    logic          valid1, last1, busy1, done1;

    int checks = 0;
    int errors = 0;

    rom_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(7), .LOOP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0),
        .rom_addr(addr0), .rom_dout(rom0),
        .m_data(data0), .m_valid(valid0), .m_ready(ready0), .m_last(last0),
        .busy(busy0), .done(done0)
    );

    rom_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(3), .LOOP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1),
        .rom_addr(addr1), .rom_dout(rom1),
        .m_data(data1), .m_valid(valid1), .m_ready(ready1), .m_last(last1),
        .busy(busy1), .done(done1)
    );

    // ROM contents: word i holds i+100, one-cycle read latency
    always @(posedge clk) begin
        rom0 <= DW'(addr0) + DW'(100);
        rom1 <= DW'(addr1) + DW'(100);
    end

    // A push into a full buffer without a simultaneous pop would lose a word
    always @(negedge clk) begin
        if (!rst && dut0.u_fifo.push && (dut0.u_fifo.occ == 2'd2) && !dut0.u_fifo.pop) begin
            errors++;
            $display("FAIL fifo_overflow: push into full buffer, occ=%0d required <2", dut0.u_fifo.occ);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== '0 || data0 !== '0 || last0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b busy=%0b done=%0b addr=%0d data=%0d last=%0b required all 0",
                     valid0, busy0, done0, addr0, data0, last0);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== '0) begin
            errors++;
            $display("FAIL reset_idle: valid=%0b busy=%0b addr=%0d required 0 0 0", valid0, busy0, addr0);
        end
    endtask

    task automatic test_stream();
        logic explast;
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL stream_lat0: valid=%0b busy=%0b required 0 1", valid0, busy0);
        end
        tick();
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_lat1: valid=%0b required 0", valid0);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            explast = (i == 7);
            checks++;
            if (valid0 !== 1'b1 || data0 !== DW'(100 + i) || last0 !== explast) begin
                errors++;
                $display("FAIL stream_word%0d: valid=%0b data=%0d last=%0b required 1 %0d %0b",
                         i, valid0, data0, last0, 100 + i, explast);
            end
            tick();
        end
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_predone: done=%0b busy=%0b valid=%0b required 0 1 0", done0, busy0, valid0);
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_done: done=%0b busy=%0b required 1 0", done0, busy0);
        end
        tick();
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_pulse: done=%0b required 0", done0);
        end
    endtask

    task automatic test_backpressure();
        int            exp_q[$];
        int            expw;
        int            n_done = 0;
        logic          pv = 1'b0, pr = 1'b0, explast;
        logic [DW-1:0] pd = '0;
        bit            fin = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(100 + i);
        ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (pv && !pr) begin
                checks++;
                if (valid0 !== 1'b1 || data0 !== pd) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%0b data=%0d required 1 %0d", valid0, data0, pd);
                end
            end
            checks++;
            if (dut0.u_fifo.occ > 2'd2) begin
                errors++;
                $display("FAIL bp_occ: occ=%0d required <=2", dut0.u_fifo.occ);
            end
            if (done0 === 1'b1) begin
                n_done++;
                fin = 1;
            end
            ready0 = 1'($urandom_range(0, 1));
            if (valid0 && ready0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: data=%0d required no further word", data0);
                end else begin
                    expw    = exp_q.pop_front();
                    explast = (exp_q.size() == 0);
                    if (data0 !== DW'(expw) || last0 !== explast) begin
                        errors++;
                        $display("FAIL bp_word: data=%0d last=%0b required %0d %0b", data0, last0, expw, explast);
                    end
                end
            end
            pv = valid0;
            pr = ready0;
            pd = data0;
            if (!fin) tick();
        end
        checks++;
        if (!fin || exp_q.size() != 0 || n_done != 1) begin
            errors++;
            $display("FAIL bp_complete: done_seen=%0d words_left=%0d required 1 0", n_done, exp_q.size());
        end
        ready0 = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_start_ignored();
        int n = 0;
        int n_done = 0;
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            start0 = (cyc == 4);
            if (done0 === 1'b1) n_done++;
            if (valid0 && ready0) begin
                checks++;
                if (data0 !== DW'(100 + n)) begin
                    errors++;
                    $display("FAIL ign_word%0d: data=%0d required %0d", n, data0, 100 + n);
                end
                n++;
            end
            tick();
        end
        start0 = 1'b0;
        checks++;
        if (n != 8 || n_done != 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ign_count: words=%0d dones=%0d busy=%0b required 8 1 0", n, n_done, busy0);
        end
    endtask

    task automatic test_loop();
        int   n = 0;
        logic explast;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int cyc = 0; cyc < 60 && n < 12; cyc++) begin
            checks++;
            if (done1 !== 1'b0) begin
                errors++;
                $display("FAIL loop_nodone: done=%0b required 0", done1);
            end
            if (valid1 && ready1) begin
                explast = ((n % 4) == 3);
                checks++;
                if (data1 !== DW'(100 + (n % 4)) || last1 !== explast) begin
                    errors++;
                    $display("FAIL loop_word%0d: data=%0d last=%0b required %0d %0b",
                             n, data1, last1, 100 + (n % 4), explast);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 12 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL loop_count: words=%0d busy=%0b required 12 1", n, busy1);
        end
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: busy=%0b valid=%0b done=%0b required 0 0 0", busy1, valid1, done1);
        end
    endtask

    task automatic test_stop_stalled();
        int n = 0;
        int n_done = 0;
        ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        checks++;
        if (valid0 !== 1'b1 || data0 !== DW'(100) || dut0.u_fifo.occ !== 2'd2) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b data=%0d occ=%0d required 1 100 2", valid0, data0, dut0.u_fifo.occ);
        end
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== '0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL stop_flush: valid=%0b busy=%0b addr=%0d done=%0b required 0 0 0 0",
                     valid0, busy0, addr0, done0);
        end
        tick();
        checks++;
        if (done0 !== 1'b0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL stop_nodone: done=%0b valid=%0b required 0 0", done0, valid0);
        end
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done0 === 1'b1) n_done++;
            if (valid0 && ready0) begin
                checks++;
                if (data0 !== DW'(100 + n)) begin
                    errors++;
                    $display("FAIL restart_word%0d: data=%0d required %0d", n, data0, 100 + n);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 8 || n_done != 1) begin
            errors++;
            $display("FAIL restart_count: words=%0d dones=%0d required 8 1", n, n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        checks++;
        if (valid0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid=%0b busy=%0b required 1 1", valid0, busy0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== '0) begin
            errors++;
            $display("FAIL rst_async: valid=%0b busy=%0b done=%0b addr=%0d required 0 0 0 0",
                     valid0, busy0, done0, addr0);
        end
        tick();
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== '0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: valid=%0b busy=%0b addr=%0d done=%0b required 0 0 0 0",
                     valid0, busy0, addr0, done0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_loop();
        test_stop_stalled();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
